// File: rtl/pixel_pattern_source_pkg.sv
// Shared definitions for the pixel pattern source: FSM state encoding,
// checksum constants and byte-order helpers.
package pixel_pattern_source_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    PIXEL  = 3'd2,
    CK_LO  = 3'd3,
    CK_HI  = 3'd4,
    PAD    = 3'd5
  } stateT;

  localparam int unsigned ChecksumWordCount = 2;
  localparam logic [16:0] FletcherModulus   = 17'd65535;

  // Host value to little-endian bus word.
  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // (x + y) mod 65535 for x already in [0,65534]; a single conditional
  // subtract suffices because the sum never reaches 2*65535.
  function automatic logic [15:0] modAdd(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= FletcherModulus) sum = sum - FletcherModulus;
    return sum[15:0];
  endfunction

endpackage

// File: rtl/pixel_pattern_source_checksum.sv
// fletcher32_accum: running Fletcher-32 sums over 16-bit host words.
//   clk, rst  clock, asynchronous active-high reset
//   clr       restart both sums at zero (combines with en: clear-then-add)
//   en        accumulate din this cycle
//   din       16-bit host value
//   a, b      running sums in [0,65534], valid the cycle after en
module fletcher32_accum
  import pixel_pattern_source_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] a,
  output logic [15:0] b
);

  logic [15:0] aBase, bBase, aNext, bNext;

  always_comb begin
    aBase = clr ? '0 : a;
    bBase = clr ? '0 : b;
    aNext = modAdd(aBase, din);
    bNext = modAdd(bBase, aNext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (en) begin
      a <= aNext;
      b <= bNext;
    end else if (clr) begin
      a <= '0;
      b <= '0;
    end
  end

endmodule

// File: rtl/pixel_pattern_source.sv
// pixel_pattern_source: emits one test image per start as little-endian
// 16-bit words: header, (thumbnail-filtered) ramp pixels, Fletcher-32
// checksum {B,A}, zero padding.
//   clk, rst       clock, asynchronous active-high reset
//   start          1-cycle pulse, accepted only when idle
//   pixel_initial  host value of full-image pixel 0
//   pixel_delta    host increment per full-image pixel index
//   hdr_idx        header word index requested; hdr_word answers same cycle
//   w_valid/w_ready/w_data  registered valid/ready word stream
//   busy           image in progress
//   done           1-cycle pulse after the final word is accepted
module pixel_pattern_source
  import pixel_pattern_source_pkg::*;
#(
  parameter int unsigned HeaderWordCount   = 4,
  parameter int unsigned ImageWidth        = 16,
  parameter int unsigned ImageHeight       = 8,
  parameter int unsigned PaddingWordCount  = 0,
  parameter int unsigned PixelFilterPeriod = 1,
  parameter int unsigned PixelFilterKeep   = 1,
  localparam int unsigned HdrIdxW = (HeaderWordCount > 1) ? $clog2(HeaderWordCount) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        pixel_initial,
  input  logic [15:0]        pixel_delta,
  output logic [HdrIdxW-1:0] hdr_idx,
  input  logic [15:0]        hdr_word,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [15:0]        w_data,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PixelCount = ImageWidth * ImageHeight;
  localparam int unsigned FullW      = ImageWidth * PixelFilterPeriod / PixelFilterKeep;
  localparam int unsigned JumpMul    = PixelFilterPeriod - PixelFilterKeep + 1;
  localparam int unsigned MaxSeg0    = (PixelCount > HeaderWordCount) ? PixelCount : HeaderWordCount;
  localparam int unsigned MaxSeg1    = (MaxSeg0 > PaddingWordCount) ? MaxSeg0 : PaddingWordCount;
  localparam int unsigned CntW       = (MaxSeg1 > 1) ? $clog2(MaxSeg1) : 1;
  localparam int unsigned GxW        = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int unsigned RunW       = (PixelFilterKeep > 1) ? $clog2(PixelFilterKeep) : 1;

  localparam logic [15:0]        XMul       = 16'(JumpMul);
  localparam logic [15:0]        RowMul     = 16'(FullW);
  localparam logic [15:0]        YMul       = 16'(JumpMul * FullW);
  localparam logic [CntW-1:0]    HdrLast    = CntW'(HeaderWordCount - 1);
  localparam logic [CntW-1:0]    PixLast    = CntW'(PixelCount - 1);
  localparam logic [CntW-1:0]    PadLast    = CntW'(PaddingWordCount - 1);
  localparam logic [HdrIdxW-1:0] HdrIdxLast = HdrIdxW'(HeaderWordCount - 1);
  localparam logic [GxW-1:0]     GxLast     = GxW'(ImageWidth - 1);
  localparam logic [RunW-1:0]    RunLast    = RunW'(PixelFilterKeep - 1);

  stateT state, stateNext;
  logic [CntW-1:0] wordCnt;

  // Step constants latched at start.
  logic [15:0] deltaR, xStep, rowStep, yStep;
  // Generator for the next pixel to be loaded.
  logic [15:0]     genVal, genBase;
  logic [GxW-1:0]  genX;
  logic [RunW-1:0] genRun, genRowRun;

  logic [15:0] ckA, ckB, ckDin;
  logic        ckEn;

  logic        accept, inIdle, load, hdrLoad, pixLoad, goIdle, startAcc;
  logic [15:0] loadWord;

  logic [15:0]     cDelta, cX, cRow, cY, gVal, gBase, advVal, advBase;
  logic [GxW-1:0]  gX, advX;
  logic [RunW-1:0] gRun, gRowRun, advRun, advRowRun;

  // While idle the generator view comes straight from the inputs so the
  // first pixel can be loaded in the start cycle when there is no header.
  always_comb begin
    inIdle  = (state == IDLE);
    cDelta  = inIdle ? pixel_delta : deltaR;
    cX      = inIdle ? 16'(pixel_delta * XMul)   : xStep;
    cRow    = inIdle ? 16'(pixel_delta * RowMul) : rowStep;
    cY      = inIdle ? 16'(pixel_delta * YMul)   : yStep;
    gVal    = inIdle ? pixel_initial : genVal;
    gBase   = inIdle ? pixel_initial : genBase;
    gX      = inIdle ? '0 : genX;
    gRun    = inIdle ? '0 : genRun;
    gRowRun = inIdle ? '0 : genRowRun;

    advX      = gX;
    advRun    = gRun;
    advRowRun = gRowRun;
    advBase   = gBase;
    advVal    = gVal;
    if (gX == GxLast) begin
      advX   = '0;
      advRun = '0;
      if (gRowRun == RunLast) begin
        advRowRun = '0;
        advBase   = gBase + cY;
      end else begin
        advRowRun = gRowRun + RunW'(1);
        advBase   = gBase + cRow;
      end
      advVal = advBase;
    end else begin
      advX = gX + GxW'(1);
      if (gRun == RunLast) begin
        advRun = '0;
        advVal = gVal + cX;
      end else begin
        advRun = gRun + RunW'(1);
        advVal = gVal + cDelta;
      end
    end
  end

  // The checksum accumulates when a word is loaded into the output register
  // rather than when it is accepted: every loaded word is later accepted, and
  // this leaves A/B settled before CK_LO/CK_HI are loaded back-to-back.
  always_comb begin
    stateNext = state;
    accept    = w_valid && w_ready;
    load      = 1'b0;
    hdrLoad   = 1'b0;
    pixLoad   = 1'b0;
    goIdle    = 1'b0;
    startAcc  = 1'b0;
    loadWord  = '0;
    ckEn      = 1'b0;
    ckDin     = '0;

    case (state)
      IDLE: begin
        if (start) begin
          startAcc = 1'b1;
          load     = 1'b1;
          if (HeaderWordCount > 0) begin
            stateNext = HEADER;
            hdrLoad   = 1'b1;
          end else begin
            stateNext = PIXEL;
            pixLoad   = 1'b1;
          end
        end
      end
      HEADER: begin
        if (accept) begin
          load = 1'b1;
          if (wordCnt == HdrLast) begin
            stateNext = PIXEL;
            pixLoad   = 1'b1;
          end else begin
            hdrLoad = 1'b1;
          end
        end
      end
      PIXEL: begin
        if (accept) begin
          load = 1'b1;
          if (wordCnt == PixLast) begin
            stateNext = CK_LO;
            loadWord  = swap16(ckA);
          end else begin
            pixLoad = 1'b1;
          end
        end
      end
      CK_LO: begin
        if (accept) begin
          load      = 1'b1;
          stateNext = CK_HI;
          loadWord  = swap16(ckB);
        end
      end
      CK_HI: begin
        if (accept) begin
          if (PaddingWordCount > 0) begin
            load      = 1'b1;
            stateNext = PAD;
          end else begin
            goIdle    = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      PAD: begin
        if (accept) begin
          if (wordCnt == PadLast) begin
            goIdle    = 1'b1;
            stateNext = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (hdrLoad) begin
      loadWord = swap16(hdr_word);
      ckEn     = 1'b1;
      ckDin    = hdr_word;
    end
    if (pixLoad) begin
      loadWord = swap16(gVal);
      ckEn     = 1'b1;
      ckDin    = gVal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid   <= 1'b0;
      w_data    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wordCnt   <= '0;
      hdr_idx   <= '0;
      deltaR    <= '0;
      xStep     <= '0;
      rowStep   <= '0;
      yStep     <= '0;
      genVal    <= '0;
      genBase   <= '0;
      genX      <= '0;
      genRun    <= '0;
      genRowRun <= '0;
    end else begin
      done <= goIdle;

      if (load) begin
        w_valid <= 1'b1;
        w_data  <= loadWord;
        wordCnt <= (stateNext != state) ? '0 : wordCnt + CntW'(1);
      end else if (goIdle) begin
        w_valid <= 1'b0;
        w_data  <= '0;
      end

      if (startAcc)    busy <= 1'b1;
      else if (goIdle) busy <= 1'b0;

      if (startAcc) begin
        deltaR  <= cDelta;
        xStep   <= cX;
        rowStep <= cRow;
        yStep   <= cY;
      end

      if (hdrLoad) hdr_idx <= (hdr_idx == HdrIdxLast) ? '0 : hdr_idx + HdrIdxW'(1);

      if (pixLoad) begin
        genVal    <= advVal;
        genBase   <= advBase;
        genX      <= advX;
        genRun    <= advRun;
        genRowRun <= advRowRun;
      end else if (startAcc) begin
        genVal    <= gVal;
        genBase   <= gBase;
        genX      <= gX;
        genRun    <= gRun;
        genRowRun <= gRowRun;
      end
    end
  end

  fletcher32_accum u_checksum (
    .clk (clk),
    .rst (rst),
    .clr (startAcc),
    .en  (ckEn),
    .din (ckDin),
    .a   (ckA),
    .b   (ckB)
  );

endmodule

// File: tb/tb_pixel_pattern_source.sv
// Directed bench for pixel_pattern_source over three parameter sets:
//   A: Hdr=0, W=2, H=1           B: Hdr=0, W=4, H=3, Period=8, Keep=2
//   C: Hdr=2, W=4, H=2, Pad=3, Period=3, Keep=2
module tb_pixel_pattern_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        startDrv, readyDrv;
  logic [15:0] pInit, pDelta;
  int          sel;

  logic        aStart, aReady, aValid, aBusy, aDone;
  logic        bStart, bReady, bValid, bBusy, bDone;
  logic        cStart, cReady, cValid, cBusy, cDone;
  logic [15:0] aData, bData, cData, cHdrWord;
  logic [0:0]  aHdrIdx, bHdrIdx, cHdrIdx;
  logic        selValid, selBusy, selDone;
  logic [15:0] selData;

  always_comb begin
    aStart = startDrv && (sel == 0);
    bStart = startDrv && (sel == 1);
    cStart = startDrv && (sel == 2);
    aReady = readyDrv && (sel == 0);
    bReady = readyDrv && (sel == 1);
    cReady = readyDrv && (sel == 2);
    cHdrWord = (cHdrIdx == 1'b0) ? 16'h1234 : 16'h5678;
    case (sel)
      0:       begin selValid = aValid; selData = aData; selBusy = aBusy; selDone = aDone; end
      1:       begin selValid = bValid; selData = bData; selBusy = bBusy; selDone = bDone; end
      default: begin selValid = cValid; selData = cData; selBusy = cBusy; selDone = cDone; end
    endcase
  end

  pixel_pattern_source #(
    .HeaderWordCount(0), .ImageWidth(2), .ImageHeight(1), .PaddingWordCount(0),
    .PixelFilterPeriod(1), .PixelFilterKeep(1)
  ) dutA (
    .clk(clk), .rst(rst), .start(aStart), .pixel_initial(pInit), .pixel_delta(pDelta),
    .hdr_idx(aHdrIdx), .hdr_word(16'h0000), .w_valid(aValid), .w_ready(aReady),
    .w_data(aData), .busy(aBusy), .done(aDone)
  );

  pixel_pattern_source #(
    .HeaderWordCount(0), .ImageWidth(4), .ImageHeight(3), .PaddingWordCount(0),
    .PixelFilterPeriod(8), .PixelFilterKeep(2)
  ) dutB (
    .clk(clk), .rst(rst), .start(bStart), .pixel_initial(pInit), .pixel_delta(pDelta),
    .hdr_idx(bHdrIdx), .hdr_word(16'h0000), .w_valid(bValid), .w_ready(bReady),
    .w_data(bData), .busy(bBusy), .done(bDone)
  );

  pixel_pattern_source #(
    .HeaderWordCount(2), .ImageWidth(4), .ImageHeight(2), .PaddingWordCount(3),
    .PixelFilterPeriod(3), .PixelFilterKeep(2)
  ) dutC (
    .clk(clk), .rst(rst), .start(cStart), .pixel_initial(pInit), .pixel_delta(pDelta),
    .hdr_idx(cHdrIdx), .hdr_word(cHdrWord), .w_valid(cValid), .w_ready(cReady),
    .w_data(cData), .busy(cBusy), .done(cDone)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] gotQ[$];
  logic [15:0] expQ[$];

  typedef struct {
    int                 dut;
    logic [15:0]        init;
    logic [15:0]        delta;
    int                 n;
    logic [0:13][15:0]  exp;
  } vecT;

  vecT vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [15:0] tbSwap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // Reference stream from the direct coordinate formula.
  task automatic buildModel(input int hdrN, input int w, input int h, input int p, input int k,
                            input int padN, input logic [15:0] init, input logic [15:0] delta);
    int ca, cb, fullW, kx, ky, px, py, pidx;
    logic [15:0] v;
    logic [15:0] hdrTab[2];
    hdrTab[0] = 16'h1234;
    hdrTab[1] = 16'h5678;
    expQ.delete();
    ca = 0;
    cb = 0;
    fullW = w * p / k;
    for (int i = 0; i < hdrN; i++) begin
      v  = hdrTab[i];
      ca = (ca + int'(v)) % 65535;
      cb = (cb + ca) % 65535;
      expQ.push_back(tbSwap(v));
    end
    for (int i = 0; i < w * h; i++) begin
      kx   = i % w;
      ky   = i / w;
      px   = (kx / k) * p + kx % k;
      py   = (ky / k) * p + ky % k;
      pidx = py * fullW + px;
      v    = 16'(int'(init) + pidx * int'(delta));
      ca   = (ca + int'(v)) % 65535;
      cb   = (cb + ca) % 65535;
      expQ.push_back(tbSwap(v));
    end
    expQ.push_back(tbSwap(16'(ca)));
    expQ.push_back(tbSwap(16'(cb)));
    for (int i = 0; i < padN; i++) expQ.push_back(16'h0000);
  endtask

  task automatic compareModel(input string name);
    logic [15:0] g;
    check($sformatf("%s count", name), 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      g = (i < gotQ.size()) ? gotQ[i] : 16'hxxxx;
      check($sformatf("%s word%0d", name, i), 32'(g), 32'(expQ[i]));
    end
  endtask

  task automatic compareVec(input int vi, input string name);
    logic [15:0] g;
    check($sformatf("%s count", name), 32'(gotQ.size()), 32'(vecs[vi].n));
    for (int i = 0; i < vecs[vi].n; i++) begin
      g = (i < gotQ.size()) ? gotQ[i] : 16'hxxxx;
      check($sformatf("%s word%0d", name, i), 32'(g), 32'(vecs[vi].exp[i]));
    end
  endtask

  // Runs one image on DUT s, collecting every accepted word into gotQ.
  // All sampling happens at negedges; ready is driven for the next posedge.
  task automatic runImage(input int s, input logic [15:0] init, input logic [15:0] delta,
                          input bit rnd, input int glitchAt, input bit chain,
                          input logic [15:0] chainInit, input logic [15:0] chainDelta,
                          input bit skipStart, input int expWords, input string name);
    int doneIter;
    bit prevStall;
    logic [15:0] prevData;
    gotQ.delete();
    sel       = s;
    doneIter  = -1;
    prevStall = 1'b0;
    prevData  = '0;
    if (!skipStart) begin
      pInit  = init;
      pDelta = delta;
      @(negedge clk);
      startDrv = 1'b1;
      @(negedge clk);
      startDrv = 1'b0;
    end
    check($sformatf("%s first busy/valid", name), 32'({selBusy, selValid}), 32'b11);
    for (int iter = 0; iter < 2000; iter++) begin
      readyDrv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (iter == glitchAt) begin
        pInit    = init ^ 16'h5A5A;
        pDelta   = delta + 16'd3;
        startDrv = 1'b1;
      end else begin
        startDrv = 1'b0;
      end
      if (prevStall)
        check($sformatf("%s hold", name), 32'({selValid, selData}), 32'({1'b1, prevData}));
      if (selDone) begin
        doneIter = iter;
        check($sformatf("%s idle at done", name), 32'({selBusy, selValid}), 32'b00);
        break;
      end
      if (selValid && readyDrv) gotQ.push_back(selData);
      prevStall = selValid && !readyDrv;
      prevData  = selData;
      @(negedge clk);
    end
    if (doneIter < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=no done want=done", name);
    end
    if (!rnd && doneIter >= 0)
      check($sformatf("%s zero-bubble cycles", name), 32'(doneIter), 32'(expWords));
    if (chain) begin
      pInit    = chainInit;
      pDelta   = chainDelta;
      startDrv = 1'b1;
    end
    @(negedge clk);
    startDrv = 1'b0;
    check($sformatf("%s done width", name), 32'(selDone), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 16'h0001, 16'h0001, 4,
                {16'h0100, 16'h0200, 16'h0300, 16'h0400, {10{16'h0000}}}};
    vecs[1] = '{0, 16'hFFFF, 16'h0001, 4,
                {16'hFFFF, 16'h0000, 16'h0000, 16'h0000, {10{16'h0000}}}};
    vecs[2] = '{0, 16'h1000, 16'h0010, 4,
                {16'h0010, 16'h1010, 16'h1020, 16'h1030, {10{16'h0000}}}};
    vecs[3] = '{0, 16'h8000, 16'h8000, 4,
                {16'h0080, 16'h0000, 16'h0080, 16'h0100, {10{16'h0000}}}};
    vecs[4] = '{0, 16'hFFFE, 16'h0001, 4,
                {16'hFEFF, 16'hFFFF, 16'hFEFF, 16'hFDFF, {10{16'h0000}}}};
    vecs[5] = '{1, 16'h0000, 16'h0001, 14,
                {16'h0000, 16'h0100, 16'h0800, 16'h0900, 16'h1000, 16'h1100, 16'h1800,
                 16'h1900, 16'h8000, 16'h8100, 16'h8800, 16'h8900, 16'h7602, 16'hCC07}};

    rst      = 1'b1;
    startDrv = 1'b0;
    readyDrv = 1'b0;
    sel      = 0;
    pInit    = '0;
    pDelta   = '0;
    repeat (3) @(negedge clk);
    check("reset A", 32'({aValid, aData, aBusy, aDone, aHdrIdx}), 32'd0);
    check("reset C", 32'({cValid, cData, cBusy, cDone, cHdrIdx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      runImage(vecs[v].dut, vecs[v].init, vecs[v].delta, 1'b0, -1, 1'b0, '0, '0, 1'b0,
               vecs[v].n, $sformatf("vec%0d", v));
      compareVec(v, $sformatf("vec%0d", v));
    end

    buildModel(0, 4, 3, 8, 2, 0, 16'h00FF, 16'h0100);
    runImage(1, 16'h00FF, 16'h0100, 1'b1, -1, 1'b0, '0, '0, 1'b0, 14, "thumbRand");
    compareModel("thumbRand");

    buildModel(2, 4, 2, 3, 2, 3, 16'h0010, 16'h0102);
    runImage(2, 16'h0010, 16'h0102, 1'b1, -1, 1'b0, '0, '0, 1'b0, 15, "hdrPadRand");
    compareModel("hdrPadRand");

    // Reset in the middle of PIXEL, then a clean image.
    sel      = 2;
    pInit    = 16'hABCD;
    pDelta   = 16'h0011;
    readyDrv = 1'b1;
    @(negedge clk);
    startDrv = 1'b1;
    @(negedge clk);
    startDrv = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-abort busy", 32'(cBusy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort async", 32'({cValid, cData, cBusy, cDone, cHdrIdx}), 32'd0);
    @(negedge clk);
    check("abort held", 32'({cValid, cData, cBusy, cDone, cHdrIdx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort no done", 32'({cDone, cValid}), 32'd0);
    buildModel(2, 4, 2, 3, 2, 3, 16'hABCD, 16'h0011);
    runImage(2, 16'hABCD, 16'h0011, 1'b0, -1, 1'b0, '0, '0, 1'b0, 15, "afterAbort");
    compareModel("afterAbort");

    // Start while busy must not disturb the running image.
    buildModel(2, 4, 2, 3, 2, 3, 16'h4321, 16'h0007);
    runImage(2, 16'h4321, 16'h0007, 1'b0, 5, 1'b0, '0, '0, 1'b0, 15, "busyStart");
    compareModel("busyStart");

    // Start in the done cycle is accepted.
    runImage(0, vecs[0].init, vecs[0].delta, 1'b0, -1, 1'b1, vecs[1].init, vecs[1].delta,
             1'b0, 4, "chainFirst");
    compareVec(0, "chainFirst");
    runImage(0, vecs[1].init, vecs[1].delta, 1'b0, -1, 1'b0, '0, '0, 1'b1, 4, "chainSecond");
    compareVec(1, "chainSecond");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
